unpack_rd_data: RTL and testbench

//  Read-side counterpart of build_wr_data: accepts 128-bit words returned by the DRAM

---
 rtl/ddr_pkg.sv | 22 ++
 rtl/unpack_rd_data.sv | 118 +++++++++++
 tb/tb_unpack_rd_data.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
//   Shared DDR word / pixel geometry for the frame-buffer write packer
//   (build_wr_data) and the read unpacker (unpack_rd_data). Both sides take
//   their widths from here, so pack and unpack widths cannot diverge.
//   Contents:
//     DDR_WORD_W       width of one DRAM word
//     PIXEL_W          width of one pixel
//     PIXELS_PER_WORD  pixels carried by one DRAM word
//     ddr_word_t       one DRAM word
//     pixel_t          one pixel
// ---------------------------------------------------------------------------
package ddr_pkg;

    localparam int DDR_WORD_W      = 128;
    localparam int PIXEL_W         = 16;
    localparam int PIXELS_PER_WORD = DDR_WORD_W / PIXEL_W;

    typedef logic [DDR_WORD_W-1:0] ddr_word_t;
    typedef logic [PIXEL_W-1:0]    pixel_t;

endpackage : ddr_pkg

// File: rtl/unpack_rd_data.sv
// ---------------------------------------------------------------------------
// unpack_rd_data
//   Splits DRAM read words into a pixel stream, one pixel per clock. Pixel 0
//   of a word is data_in[OUT_W-1:0], mirroring the write packer so a
//   write/read round trip preserves pixel order. A one-word prefetch slot (B)
//   behind the active word (A) keeps the output gap-free across word
//   boundaries. All outputs come from registers; ready_in additionally
//   depends on the reset pin so nothing is accepted while held in reset.
//
//   Ports:
//     clk_in     in   clock, all state updates on posedge
//     rst_in     in   asynchronous reset, active low
//     valid_in   in   data_in holds a word
//     ready_in   out  a word can be taken this cycle
//     data_in    in   memory word, pixel k at [k*OUT_W +: OUT_W]
//     valid_out  out  data_out holds a pixel
//     ready_out  in   downstream takes the pixel this cycle
//     data_out   out  current pixel
//     last_out   out  final pixel of the current word
// ---------------------------------------------------------------------------
module unpack_rd_data
    import ddr_pkg::*;
#(
    parameter int IN_W  = DDR_WORD_W,
    parameter int OUT_W = PIXEL_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [IN_W-1:0]  data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [OUT_W-1:0] data_out,
    output logic             last_out
);

    localparam int N     = IN_W / OUT_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if ((IN_W % OUT_W) != 0) begin : g_width_check
        $error("unpack_rd_data: IN_W must be a multiple of OUT_W");
    end

    logic [IN_W-1:0]  a_q, a_d;
    logic             a_vld_q, a_vld_d;
    logic [IN_W-1:0]  b_q, b_d;
    logic             b_vld_q, b_vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic accept;
    logic pop;
    logic is_last;

    always_comb begin
        ready_in  = rst_in & ~b_vld_q;
        accept    = valid_in & ready_in;
        valid_out = a_vld_q;
        is_last   = (idx_q == IDX_W'(N - 1));
        last_out  = a_vld_q & is_last;
        pop       = a_vld_q & ready_out;
        data_out  = a_q[idx_q*OUT_W +: OUT_W];

        a_d     = a_q;
        a_vld_d = a_vld_q;
        b_d     = b_q;
        b_vld_d = b_vld_q;
        idx_d   = idx_q;

        if (!a_vld_q) begin
            // B is never occupied while A is empty, so a new word goes straight to A.
            if (accept) begin
                a_d     = data_in;
                a_vld_d = 1'b1;
                idx_d   = '0;
            end
        end else if (pop && !is_last) begin
            idx_d = idx_q + IDX_W'(1);
            if (accept) begin
                b_d     = data_in;
                b_vld_d = 1'b1;
            end
        end else if (pop) begin
            // Word finished: refill A from B, else from the input (no bubble),
            // else go idle. ready_in is low whenever B is full, so the
            // B-refill branch never coincides with an accept.
            idx_d = '0;
            if (b_vld_q) begin
                a_d     = b_q;
                b_vld_d = 1'b0;
            end else if (accept) begin
                a_d = data_in;
            end else begin
                a_vld_d = 1'b0;
            end
        end else if (accept) begin
            b_d     = data_in;
            b_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            a_q     <= '0;
            a_vld_q <= 1'b0;
            b_q     <= '0;
            b_vld_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            a_vld_q <= a_vld_d;
            b_q     <= b_d;
            b_vld_q <= b_vld_d;
            idx_q   <= idx_d;
        end
    end

endmodule : unpack_rd_data

// File: tb/tb_unpack_rd_data.sv
module tb_unpack_rd_data;
    import ddr_pkg::*;

    localparam int N = PIXELS_PER_WORD;

    logic      clk_in = 1'b0;
    logic      rst_in = 1'b1;
    logic      valid_in = 1'b0;
    logic      ready_in;
    ddr_word_t data_in = '0;
    logic      valid_out;
    logic      ready_out = 1'b0;
    pixel_t    data_out;
    logic      last_out;

    unpack_rd_data #(.IN_W(DDR_WORD_W), .OUT_W(PIXEL_W)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .last_out  (last_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words held by the block, and how many pixels of the
    // front word have been consumed.
    ddr_word_t m_words[$];
    int        m_idx = 0;
    // Upstream words waiting to be offered, and pixels seen leaving the DUT.
    ddr_word_t send_q[$];
    pixel_t    got[$];

    localparam ddr_word_t W0 = 128'hBEEF_DEAD_3210_7654_5678_1234_DCBA_ABCD;
    localparam ddr_word_t W1 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pixel_t px_of(input ddr_word_t w, input int k);
        return w[k*PIXEL_W +: PIXEL_W];
    endfunction

    // One clock: compare outputs to the model, drive inputs, advance the model.
    task automatic do_cycle(input logic allow, input logic rout);
        logic   e_valid, e_ready, e_last, acc, pp;
        pixel_t e_data;
        @(negedge clk_in);
        e_valid = (m_words.size() > 0);
        e_ready = (m_words.size() < 2);
        e_last  = e_valid && (m_idx == N - 1);
        e_data  = e_valid ? px_of(m_words[0], m_idx) : '0;
        chk("valid_out", 128'(valid_out), 128'(e_valid));
        chk("ready_in", 128'(ready_in), 128'(e_ready));
        chk("last_out", 128'(last_out), 128'(e_last));
        if (e_valid) chk("data_out", 128'(data_out), 128'(e_data));

        valid_in  = allow && (send_q.size() > 0);
        data_in   = (send_q.size() > 0) ? send_q[0] : ddr_word_t'(0);
        ready_out = rout;
        acc = valid_in && e_ready;
        pp  = e_valid && rout;
        if (pp) got.push_back(data_out);
        @(posedge clk_in);
        if (pp) begin
            m_idx++;
            if (m_idx == N) begin
                void'(m_words.pop_front());
                m_idx = 0;
            end
        end
        if (acc) m_words.push_back(send_q.pop_front());
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, holds 2 clocks.
    task automatic do_reset();
        @(negedge clk_in);
        #2;
        rst_in   = 1'b0;
        valid_in = 1'b0;
        ready_out = 1'b0;
        #1;
        chk("rst_valid_out", 128'(valid_out), 128'(0));
        chk("rst_last_out", 128'(last_out), 128'(0));
        chk("rst_data_out", 128'(data_out), 128'(0));
        chk("rst_ready_in", 128'(ready_in), 128'(0));
        m_words.delete();
        m_idx = 0;
        send_q.delete();
        repeat (2) begin
            @(negedge clk_in);
            chk("rst_hold_ready_in", 128'(ready_in), 128'(0));
            chk("rst_hold_valid_out", 128'(valid_out), 128'(0));
        end
        rst_in = 1'b1;
        #1;
        chk("rel_ready_in", 128'(ready_in), 128'(1));
    endtask

    task automatic expect_words(input string tag, input ddr_word_t ws[$]);
        chk({tag, "_count"}, 128'(got.size()), 128'(ws.size() * N));
        for (int w = 0; w < ws.size(); w++)
            for (int k = 0; k < N; k++)
                if (w * N + k < got.size())
                    chk(tag, 128'(got[w*N+k]), 128'(px_of(ws[w], k)));
    endtask

    initial begin
        pixel_t    w0_exp[8];
        ddr_word_t w2;
        ddr_word_t wl[$];
        w0_exp = '{16'hABCD, 16'hDCBA, 16'h1234, 16'h5678,
                   16'h7654, 16'h3210, 16'hDEAD, 16'hBEEF};

        // Reset, then idle with nothing offered.
        do_reset();
        repeat (2) do_cycle(1'b1, 1'b1);

        // Single word, pixel order against literal values.
        got.delete();
        send_q.push_back(W0);
        repeat (11) do_cycle(1'b1, 1'b1);
        chk("w0_count", 128'(got.size()), 128'(8));
        for (int k = 0; k < 8; k++)
            if (k < got.size()) chk("w0_order", 128'(got[k]), 128'(w0_exp[k]));

        // Two back-to-back words, gap-free across the boundary.
        got.delete();
        send_q.push_back(W0);
        send_q.push_back(W1);
        repeat (19) do_cycle(1'b1, 1'b1);
        wl = '{W0, W1};
        expect_words("w0w1", wl);

        // Backpressure after the 3rd pop.
        got.delete();
        send_q.push_back(W0);
        repeat (4) do_cycle(1'b1, 1'b1);
        repeat (5) begin
            do_cycle(1'b1, 1'b0);
            chk("bp_hold", 128'(data_out), 128'(16'h5678));
        end
        repeat (8) do_cycle(1'b1, 1'b1);
        wl = '{W0};
        expect_words("bp", wl);

        // Three words offered while the output is stalled.
        got.delete();
        w2 = {$urandom, $urandom, $urandom, $urandom};
        send_q.push_back(W0);
        send_q.push_back(W1);
        send_q.push_back(w2);
        repeat (5) do_cycle(1'b1, 1'b0);
        chk("stall_pending", 128'(send_q.size()), 128'(1));
        repeat (28) do_cycle(1'b1, 1'b1);
        wl = '{W0, W1, w2};
        expect_words("stall3", wl);

        // Reset in the middle of W0 with W1 prefetched.
        got.delete();
        send_q.push_back(W0);
        send_q.push_back(W1);
        repeat (5) do_cycle(1'b1, 1'b1);
        chk("pre_rst_pops", 128'(got.size()), 128'(4));
        do_reset();
        got.delete();
        send_q.push_back(W1);
        repeat (11) do_cycle(1'b1, 1'b1);
        wl = '{W1};
        expect_words("post_rst", wl);

        // Randomized traffic with varying valid/ready densities.
        for (int seg = 0; seg < 4; seg++) begin
            int pv, pr;
            pv = (seg == 0) ? 90 : (seg == 1) ? 30 : (seg == 2) ? 100 : 60;
            pr = (seg == 0) ? 90 : (seg == 1) ? 90 : (seg == 2) ? 20 : 60;
            for (int c = 0; c < 600; c++) begin
                if (send_q.size() < 3 && ($urandom % 3) == 0)
                    send_q.push_back({$urandom, $urandom, $urandom, $urandom});
                do_cycle(($urandom % 100) < pv, ($urandom % 100) < pr);
            end
        end
        // Drain.
        repeat (40) do_cycle(1'b1, 1'b1);
        chk("drain_empty", 128'(valid_out), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_unpack_rd_data
